// File: rtl/delay_gate_pkg.sv
// Shared types and helpers for the clocked rise/fall/turn-off delay gate array.
// Levels are three-state (0, 1, Z); delays are carried at a fixed maximum width.
package delay_gate_pkg;

    localparam int DLY_W_MAX = 16;

    typedef logic [DLY_W_MAX-1:0] dly_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } ch_state_e;

    typedef enum logic [1:0] {
        LV_ZERO = 2'b00,
        LV_ONE  = 2'b01,
        LV_HIZ  = 2'b10
    } lvl_e;

    function automatic lvl_e to_lvl(input logic en, input logic d);
        lvl_e lv;
        if (!en) begin
            lv = LV_HIZ;
        end else if (d) begin
            lv = LV_ONE;
        end else begin
            lv = LV_ZERO;
        end
        return lv;
    endfunction

    // The delay is chosen by where the output is heading, not where it comes from.
    function automatic dly_t delay_sel(input lvl_e target, input dly_t rise,
                                       input dly_t fall, input dly_t off);
        dly_t d;
        case (target)
            LV_ONE:  d = rise;
            LV_ZERO: d = fall;
            default: d = off;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/delay_gate_ch.sv
// One inertial delay channel: IDLE/PEND FSM, countdown, and its own delay registers.
// Output level is registered; y/y_oe are decoded from it.
module delay_gate_ch
    import delay_gate_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int RISE_DEF = 2,
    parameter int FALL_DEF = 2,
    parameter int OFF_DEF  = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             d_i,
    input  logic             en_i,
    input  logic             cfg_we_i,
    input  logic [CNT_W-1:0] cfg_rise_i,
    input  logic [CNT_W-1:0] cfg_fall_i,
    input  logic [CNT_W-1:0] cfg_off_i,
    output logic             y_o,
    output logic             y_oe_o,
    output logic             glitch_o,
    output ch_state_e        state_o
);

    ch_state_e        state_q, state_d;
    lvl_e             out_q, out_d;
    lvl_e             tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             glitch_q, glitch_d;
    logic [CNT_W-1:0] rise_q, fall_q, off_q;

    lvl_e             tgt_now;
    logic [CNT_W-1:0] dly;
    logic             dly_short;

    assign tgt_now   = to_lvl(en_i, d_i);
    assign dly       = CNT_W'(delay_sel(tgt_now, dly_t'(rise_q), dly_t'(fall_q), dly_t'(off_q)));
    // D of 0 or 1 both mean "next edge", so they skip the PEND state entirely.
    assign dly_short = (dly <= CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        glitch_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tgt_now != out_q) begin
                    if (dly_short) begin
                        out_d = tgt_now;
                    end else begin
                        state_d = ST_PEND;
                        tgt_d   = tgt_now;
                        cnt_d   = dly - CNT_W'(1);
                    end
                end
            end
            ST_PEND: begin
                if (tgt_now == out_q) begin
                    state_d  = ST_IDLE;
                    glitch_d = 1'b1;
                end else if (tgt_now != tgt_q) begin
                    glitch_d = 1'b1;
                    if (dly_short) begin
                        out_d   = tgt_now;
                        state_d = ST_IDLE;
                    end else begin
                        tgt_d = tgt_now;
                        cnt_d = dly - CNT_W'(1);
                    end
                end else if (cnt_q == CNT_W'(1)) begin
                    out_d   = tgt_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            out_q    <= LV_HIZ;
            tgt_q    <= LV_HIZ;
            cnt_q    <= '0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
        end
    end

    // A write only changes the registers; an in-flight countdown keeps its value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rise_q <= CNT_W'(RISE_DEF);
            fall_q <= CNT_W'(FALL_DEF);
            off_q  <= CNT_W'(OFF_DEF);
        end else if (cfg_we_i) begin
            rise_q <= cfg_rise_i;
            fall_q <= cfg_fall_i;
            off_q  <= cfg_off_i;
        end
    end

    assign y_o      = (out_q == LV_ONE);
    assign y_oe_o   = (out_q != LV_HIZ);
    assign glitch_o = glitch_q;
    assign state_o  = state_q;

    a_pend_cnt_nonzero: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == ST_PEND) |-> (cnt_q != '0));

endmodule

// File: rtl/delay_gate_array.sv
// Array of independent inertial delay channels with a shared config write port.
// The top only decodes cfg_ch and gathers per-channel status.
module delay_gate_array
    import delay_gate_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 4,
    parameter int RISE_DEF = 2,
    parameter int FALL_DEF = 2,
    parameter int OFF_DEF  = 3
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [CHANNELS-1:0]                             d_in,
    input  logic [CHANNELS-1:0]                             en,
    input  logic                                            cfg_we,
    input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                                cfg_rise,
    input  logic [CNT_W-1:0]                                cfg_fall,
    input  logic [CNT_W-1:0]                                cfg_off,
    output logic [CHANNELS-1:0]                             y,
    output logic [CHANNELS-1:0]                             y_oe,
    output logic [CHANNELS-1:0]                             busy,
    output logic [CHANNELS-1:0]                             glitch
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    ch_state_e ch_state [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic ch_we;

        // Codes at or above CHANNELS match no instance, so such writes fall away.
        assign ch_we = cfg_we && (cfg_ch == CH_W'(i));

        delay_gate_ch #(
            .CNT_W    (CNT_W),
            .RISE_DEF (RISE_DEF),
            .FALL_DEF (FALL_DEF),
            .OFF_DEF  (OFF_DEF)
        ) u_ch (
            .clk_i      (clk),
            .rst_i      (rst),
            .d_i        (d_in[i]),
            .en_i       (en[i]),
            .cfg_we_i   (ch_we),
            .cfg_rise_i (cfg_rise),
            .cfg_fall_i (cfg_fall),
            .cfg_off_i  (cfg_off),
            .y_o        (y[i]),
            .y_oe_o     (y_oe[i]),
            .glitch_o   (glitch[i]),
            .state_o    (ch_state[i])
        );

        assign busy[i] = (ch_state[i] == ST_PEND);
    end

endmodule

// File: tb/tb_delay_gate_array.sv
// Directed bench for delay_gate_array: hand-computed expectations per edge.
// Inputs change 1ns after a rising edge; outputs are checked at that same point.
module tb_delay_gate_array;

    localparam int CHANNELS = 4;
    localparam int CNT_W    = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [CHANNELS-1:0] d_in;
    logic [CHANNELS-1:0] en;
    logic                cfg_we;
    logic [1:0]          cfg_ch;
    logic [CNT_W-1:0]    cfg_rise;
    logic [CNT_W-1:0]    cfg_fall;
    logic [CNT_W-1:0]    cfg_off;
    logic [CHANNELS-1:0] y;
    logic [CHANNELS-1:0] y_oe;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] glitch;

    int n_vec = 0;
    int n_mis = 0;

    delay_gate_array #(
        .CHANNELS (CHANNELS),
        .CNT_W    (CNT_W),
        .RISE_DEF (2),
        .FALL_DEF (2),
        .OFF_DEF  (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .d_in     (d_in),
        .en       (en),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_rise (cfg_rise),
        .cfg_fall (cfg_fall),
        .cfg_off  (cfg_off),
        .y        (y),
        .y_oe     (y_oe),
        .busy     (busy),
        .glitch   (glitch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [CNT_W-1:0] r,
                             input logic [CNT_W-1:0] f, input logic [CNT_W-1:0] o);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_rise = r;
        cfg_fall = f;
        cfg_off  = o;
        step(1);
        cfg_we   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; d_in = '0; en = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_rise = '0; cfg_fall = '0; cfg_off = '0;
        step(2);
        chk("rst_y",      32'(y),      32'h0);
        chk("rst_y_oe",   32'(y_oe),   32'h0);
        chk("rst_busy",   32'(busy),   32'h0);
        chk("rst_glitch", 32'(glitch), 32'h0);

        // 1: ch0 Z->0 with default fall=2
        en = 4'b0001;
        step(1);
        rst = 1'b0;
        step(1);
        chk("t1_busy_e1", 32'(busy[0]), 32'h1);
        chk("t1_oe_e1",   32'(y_oe[0]), 32'h0);
        step(1);
        chk("t1_oe_e2",   32'(y_oe[0]), 32'h1);
        chk("t1_y_e2",    32'(y[0]),    32'h0);
        chk("t1_busy_e2", 32'(busy[0]), 32'h0);

        // 2: ch0 rise=2 latency, then rise=5 and 6-cycle pulses
        d_in[0] = 1'b1;
        step(1);
        chk("t2_y_k",    32'(y[0]),    32'h0);
        chk("t2_busy_k", 32'(busy[0]), 32'h1);
        step(1);
        chk("t2_y_k1",   32'(y[0]),    32'h1);
        cfg_write(2'd0, 4'd5, 4'd2, 4'd3);
        d_in[0] = 1'b0;
        step(1);
        chk("t2_fall_k",  32'(y[0]), 32'h1);
        step(1);
        chk("t2_fall_k1", 32'(y[0]), 32'h0);
        step(4);
        d_in[0] = 1'b1;
        step(4);
        chk("t2_rise_m3",    32'(y[0]),    32'h0);
        chk("t2_rise_busy3", 32'(busy[0]), 32'h1);
        step(1);
        chk("t2_rise_m4",    32'(y[0]),    32'h1);
        chk("t2_rise_busy4", 32'(busy[0]), 32'h0);
        step(1);

        // 3: ch1 rise=4, 2-cycle pulse is swallowed
        cfg_write(2'd1, 4'd4, 4'd2, 4'd3);
        en[1] = 1'b1;
        d_in[1] = 1'b0;
        step(2);
        chk("t3_oe_setup", 32'(y_oe[1]), 32'h1);
        d_in[1] = 1'b1;
        step(1);
        chk("t3_busy_p",  32'(busy[1]), 32'h1);
        step(1);
        chk("t3_y_p1",    32'(y[1]),    32'h0);
        d_in[1] = 1'b0;
        step(1);
        chk("t3_glitch",  32'(glitch[1]), 32'h1);
        chk("t3_busy_dn", 32'(busy[1]),   32'h0);
        chk("t3_y_hold",  32'(y[1]),      32'h0);
        step(1);
        chk("t3_glitch_clr", 32'(glitch[1]), 32'h0);
        chk("t3_y_final",    32'(y[1]),      32'h0);

        // 4: ch2 drive 1, turn off (off=3), re-enable (rise=2)
        en[2] = 1'b1;
        d_in[2] = 1'b1;
        step(2);
        chk("t4_y_setup", 32'(y[2]), 32'h1);
        en[2] = 1'b0;
        step(2);
        chk("t4_oe_k1", 32'(y_oe[2]), 32'h1);
        step(1);
        chk("t4_oe_k2", 32'(y_oe[2]), 32'h0);
        chk("t4_y_k2",  32'(y[2]),    32'h0);
        en[2] = 1'b1;
        step(1);
        chk("t4_oe_m",  32'(y_oe[2]), 32'h0);
        step(1);
        chk("t4_oe_m1", 32'(y_oe[2]), 32'h1);
        chk("t4_y_m1",  32'(y[2]),    32'h1);

        // 5: ch3 rise=3 pending (cnt=2), en drops -> retarget to Z with off=3
        cfg_write(2'd3, 4'd3, 4'd2, 4'd3);
        en[3] = 1'b1;
        d_in[3] = 1'b0;
        step(2);
        chk("t5_oe_setup", 32'(y_oe[3]), 32'h1);
        d_in[3] = 1'b1;
        step(1);
        chk("t5_busy_r", 32'(busy[3]), 32'h1);
        en[3] = 1'b0;
        step(1);
        chk("t5_glitch_r1", 32'(glitch[3]), 32'h1);
        chk("t5_busy_r1",   32'(busy[3]),   32'h1);
        chk("t5_y_r1",      32'(y[3]),      32'h0);
        step(1);
        chk("t5_glitch_r2", 32'(glitch[3]), 32'h0);
        chk("t5_oe_r2",     32'(y_oe[3]),   32'h1);
        step(1);
        chk("t5_oe_r3",     32'(y_oe[3]),   32'h0);
        chk("t5_busy_r3",   32'(busy[3]),   32'h0);

        // 6: all channels pending, then reset (with a cfg write that must be ignored)
        en   = 4'b1111;
        d_in = 4'b1010;
        step(1);
        chk("t6_all_busy", 32'(busy), 32'hf);
        rst = 1'b1;
        en  = 4'b0000;
        cfg_write(2'd1, 4'd9, 4'd9, 4'd9);
        chk("t6_rst_y",      32'(y),      32'h0);
        chk("t6_rst_oe",     32'(y_oe),   32'h0);
        chk("t6_rst_busy",   32'(busy),   32'h0);
        chk("t6_rst_glitch", 32'(glitch), 32'h0);
        rst = 1'b0;
        cfg_write(2'd0, 4'd0, 4'd2, 4'd3);
        en   = 4'b0011;
        d_in = 4'b0011;
        step(1);
        chk("t6_d0_y",    32'(y[0]),    32'h1);
        chk("t6_d0_oe",   32'(y_oe[0]), 32'h1);
        chk("t6_d0_busy", 32'(busy[0]), 32'h0);
        chk("t6_ch1_y",    32'(y[1]),    32'h0);
        chk("t6_ch1_busy", 32'(busy[1]), 32'h1);
        step(1);
        chk("t6_ch1_rise_def", 32'(y[1]), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/delay_gate_array.md
Name: delay_gate_array

Overview:
- Clocked, cycle-accurate model of gates with rise, fall and turn-off delays, generalised to CHANNELS independent 1-bit channels.
- Each channel drives a three-state output (0, 1 or Z) from a data input and an enable.
- Rise, fall and turn-off delays are counted in clock cycles and are runtime-programmable per channel.
- Inertial filtering: any input pulse shorter than the applicable delay is swallowed and flagged.
- Used in the delays lab as the synthesizable successor to the #(rise,fall,off) gate models.

Parameters:
- CHANNELS, 4, number of independent channels.
- CNT_W, 4, delay counter width; delays range 0..2^CNT_W-1 cycles.
- RISE_DEF, 2, reset value of every channel's rise delay.
- FALL_DEF, 2, reset value of every channel's fall delay.
- OFF_DEF, 3, reset value of every channel's turn-off delay.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- d_in  in  CHANNELS  per-channel data input.
- en  in  CHANNELS  per-channel output enable (0 means the target is Z).
- cfg_we  in  1  config write strobe.
- cfg_ch  in  $clog2(CHANNELS) (min 1)  channel selected for the write.
- cfg_rise  in  CNT_W  rise delay to load.
- cfg_fall  in  CNT_W  fall delay to load.
- cfg_off  in  CNT_W  turn-off delay to load.
- y  out  CHANNELS  output value; forced to 0 when y_oe=0.
- y_oe  out  CHANNELS  1 means driven, 0 means Z.
- busy  out  CHANNELS  1 while a transition is pending.
- glitch  out  CHANNELS  one-cycle pulse when a pending transition is cancelled or retargeted.

Behaviour:
- Reset (synchronous, active-high): y=0, y_oe=0 (Z), busy=0, glitch=0, all channels IDLE, config registers set to RISE_DEF/FALL_DEF/OFF_DEF. Reset overrides pending transitions and cfg_we in the same cycle.
- Per channel, the target is computed each cycle as T = en ? d_in : Z. The current output is O = y_oe ? y : Z.
- Delay selection: target 1 uses rise, target 0 uses fall, target Z uses off. A transition out of Z uses rise or fall according to the target value.
- Latency: let edge k be the first edge that samples T != O. The output shows T after edge k+D-1. D=0 behaves as D=1, so the minimum latency is one register stage.
- Channel states:
  - IDLE: O==T. On an edge where T!=O:
    - if D<=1, update O and stay in IDLE;
    - otherwise go to PEND with pend_tgt=T and cnt=D-1, and set busy=1.
  - PEND: each edge, evaluate in this order:
    - T==O: cancel, return to IDLE, glitch=1 for one cycle.
    - T!=pend_tgt: retarget, reload with the delay for the new T using the same D<=1 rule, glitch=1.
    - cnt==1: commit O=pend_tgt, go to IDLE, busy=0.
    - otherwise: cnt decrements by 1.
- busy equals (state==PEND), registered.
- Config write: at an edge with cfg_we=1, cfg_ch's three delay registers load. The new values affect only transitions that start at later edges; an in-flight cnt is not reloaded. A write with cfg_ch>=CHANNELS is ignored.
- Width rules: counters are CNT_W bits and never underflow; cnt=0 is unreachable in PEND.
- Channels are fully independent. Simultaneous events on different channels do not interact.

Decomposition:
- Package delay_gate_pkg holds:
  - a 2-state enum for IDLE/PEND;
  - a 2-bit three-state encoding for ZERO, ONE and HIZ;
  - a function delay_sel(target, rise, fall, off).
- Sub-module delay_gate_ch holds one channel: FSM, counter, config registers, with a cfg_we qualified by channel decode.
- The top level generate-instantiates CHANNELS copies and does the cfg_ch decode.

Test Plan:
1. Reset defaults, ch0: en=1, d_in=0 from reset. Required: Z->0 via fall=2, so y_oe[0]=1 and y[0]=0 after the 2nd edge post-reset, with busy[0]=1 for exactly one cycle.
2. Rise/fall latency, ch0: d_in 0->1 sampled at edge k. Required: y=1 after edge k+1. Then write cfg_rise=5 on ch0, and 1->0->1 pulses of 6 cycles each. Required: fall after 2 cycles, rise after 5 cycles.
3. Inertial rejection, ch1: rise=4, then a 2-cycle 0->1->0 pulse on d_in[1]. Required: y[1] stays 0, glitch[1] pulses once, busy[1] drops the same cycle.
4. Turn-off and re-enable, ch2: y=1 driven, en drops at edge k. Required: y_oe=0 after edge k+2 (off=3). Then en=1 at edge m. Required: y_oe=1, y=1 after edge m+1 (rise=2).
5. Retarget, ch3: while a rise is pending (cnt=2), en drops. Required: glitch=1, and the new Z target commits off=3 cycles after the retarget edge.
6. Reset mid-operation plus D=0: assert rst while all channels are PEND. Required: all outputs return to Z/0, busy=0 next cycle. Then load cfg_rise=0. Required: a rise is visible after one edge.
